// File: rtl/sigmoid_sched_pkg.sv
// Shared types and constants for the sigmoid scheduler: FSM states, Q4.12
// constants, result payload and the sigmoid knot table.
package sigmoid_sched_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned LUT_W  = 12;
  localparam int unsigned FRAC_W = 11;

  localparam logic [DATA_W-1:0] SAT_HI = 16'h7000;
  localparam logic [DATA_W-1:0] SAT_LO = 16'h9000;
  localparam logic [DATA_W-1:0] ONE_Q  = 16'h1000;
  localparam logic [DATA_W-1:0] HALF_Q = 16'h0800;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic              sat;
  } sig_res_t;

  // sigmoid(seg * 0.5) in Q.12, rounded; index 15 only feeds interpolation up to 7.0
  function automatic logic [LUT_W-1:0] sig_knot(input logic [3:0] seg);
    logic [LUT_W-1:0] v;
    case (seg)
      4'd0:    v = LUT_W'(HALF_Q);
      4'd1:    v = 12'd2550;
      4'd2:    v = 12'd2994;
      4'd3:    v = 12'd3349;
      4'd4:    v = 12'd3608;
      4'd5:    v = 12'd3785;
      4'd6:    v = 12'd3902;
      4'd7:    v = 12'd3976;
      4'd8:    v = 12'd4022;
      4'd9:    v = 12'd4051;
      4'd10:   v = 12'd4069;
      4'd11:   v = 12'd4079;
      4'd12:   v = 12'd4086;
      4'd13:   v = 12'd4090;
      4'd14:   v = 12'd4092;
      default: v = 12'd4094;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sigmoid_sched_if.sv
// Requester/result bus of the sigmoid scheduler.
interface sigmoid_sched_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
);
  import sigmoid_sched_pkg::*;

  logic [N_REQ-1:0]             req_valid;
  logic [N_REQ-1:0][DATA_W-1:0] req_x;
  logic [N_REQ-1:0]             req_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_W-1:0]            out_y;
  logic [ID_W-1:0]              out_id;
  logic                         out_sat;

  modport master (
    output req_valid, req_x, out_ready,
    input  req_ready, out_valid, out_y, out_id, out_sat
  );

  modport slave (
    input  req_valid, req_x, out_ready,
    output req_ready, out_valid, out_y, out_id, out_sat
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin selector: first set request at or after the pointer, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant_c,
  output logic [ID_W-1:0]  o_idx_c
);

  logic        w_found;
  int unsigned w_cand;

  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    w_found   = 1'b0;
    w_cand    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_cand = (32'(i_ptr) + k) % N_REQ;
      if (!w_found && i_req[w_cand]) begin
        w_found           = 1'b1;
        o_grant_c[w_cand] = 1'b1;
        o_idx_c           = ID_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/sigmoid_unit.sv
// Combinational Q4.12 sigmoid: half-step knot table with linear interpolation,
// odd symmetry for negative operands, clamp outside [-7.0, +7.0].
module sigmoid_unit
  import sigmoid_sched_pkg::*;
(
  input  logic [DATA_W-1:0] i_x,
  output sig_res_t          o_res_c
);

  logic                          w_neg;
  logic                          w_sat;
  logic [DATA_W-2:0]             w_ax;
  logic [3:0]                    w_seg;
  logic [FRAC_W-1:0]             w_frac;
  logic [LUT_W-1:0]              w_lo;
  logic [LUT_W-1:0]              w_hi;
  logic [LUT_W-1:0]              w_diff;
  logic [LUT_W+FRAC_W-1:0]       w_prod;
  logic [LUT_W-1:0]              w_interp;
  logic [LUT_W-1:0]              w_pos;

  assign w_neg = i_x[DATA_W-1];
  assign w_sat = ($signed(i_x) > $signed(SAT_HI)) || ($signed(i_x) < $signed(SAT_LO));

  // Magnitude; the only overflow case (0x8000) is already saturated.
  assign w_ax   = w_neg ? (DATA_W-1)'(-i_x) : i_x[DATA_W-2:0];
  assign w_seg  = w_ax[DATA_W-2:FRAC_W];
  assign w_frac = w_ax[FRAC_W-1:0];

  assign w_lo     = sig_knot(w_seg);
  assign w_hi     = sig_knot(4'(w_seg + 4'd1));
  assign w_diff   = w_hi - w_lo;
  assign w_prod   = (LUT_W+FRAC_W)'(w_diff) * (LUT_W+FRAC_W)'(w_frac);
  assign w_interp = LUT_W'(w_prod >> FRAC_W);
  assign w_pos    = w_lo + w_interp;

  always_comb begin
    o_res_c.sat = w_sat;
    if (w_sat) begin
      o_res_c.y = w_neg ? '0 : ONE_Q;
    end else if (w_neg) begin
      o_res_c.y = ONE_Q - DATA_W'(w_pos);
    end else begin
      o_res_c.y = DATA_W'(w_pos);
    end
  end

endmodule

// File: rtl/sigmoid_sched.sv
// Shares one sigmoid unit among N_REQ requesters: round-robin grant, operand
// capture, one-cycle evaluation, then a held result until downstream accepts.
module sigmoid_sched
  import sigmoid_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  sigmoid_sched_if.slave    bus,
  output logic [DATA_W-1:0] done_cnt
);

  state_e            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [DATA_W-1:0] r_x;
  logic [ID_W-1:0]   r_id;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_y;
  logic [ID_W-1:0]   r_out_id;
  logic              r_out_sat;
  logic [DATA_W-1:0] r_done_cnt;

  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_idx;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic              w_any;
  logic              w_accept;
  logic              w_hs;
  sig_res_t          w_res;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req     (bus.req_valid),
    .i_ptr     (r_ptr),
    .o_grant_c (w_grant),
    .o_idx_c   (w_idx)
  );

  // Datapath sees only the captured operand.
  sigmoid_unit u_sig (
    .i_x     (r_x),
    .o_res_c (w_res)
  );

  assign w_any     = |bus.req_valid;
  assign w_hs      = r_out_valid & bus.out_ready;
  assign w_accept  = rst_n && w_any &&
                     ((r_state == ST_IDLE) || ((r_state == ST_RESP) && bus.out_ready));
  assign w_ptr_nxt = ID_W'((32'(w_idx) + 32'd1) % N_REQ);

  // Grant is same-cycle so the requester sees its accept while it presents x.
  assign bus.req_ready = w_accept ? w_grant : '0;
  assign bus.out_valid = r_out_valid;
  assign bus.out_y     = r_out_y;
  assign bus.out_id    = r_out_id;
  assign bus.out_sat   = r_out_sat;
  assign done_cnt      = r_done_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_x         <= '0;
      r_id        <= '0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_id    <= '0;
      r_out_sat   <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_x   <= bus.req_x[w_idx];
        r_id  <= w_idx;
        r_ptr <= w_ptr_nxt;
      end
      if (w_hs) begin
        r_done_cnt <= r_done_cnt + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any) r_state <= ST_EVAL;
        end
        ST_EVAL: begin
          r_out_y     <= w_res.y;
          r_out_sat   <= w_res.sat;
          r_out_id    <= r_id;
          r_out_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= w_any ? ST_EVAL : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
